// File: rtl/bcd_downcounter.sv
// Loadable multi-digit BCD down-counter (countdown timer) with run/pause/resume control.
// Each preset nibble above 9 is clamped to 9 and latched as the reload value.
// Optional feature macro: AUTO_RELOAD_EN. When it is defined, the counter reloads the
// latched preset at terminal count and keeps running instead of stopping at zero.
module bcd_downcounter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_resume,
  input  logic [4*DIGITS-1:0]   i_load_val,
  output logic [4*DIGITS-1:0]   o_count,
  output logic                  o_busy,
  output logic                  o_zero,
  output logic                  o_done
);

  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

  state_e         state_q;
  logic [W-1:0]   count_q;
  logic [W-1:0]   preset_q;
  logic           busy_q;
  logic           zero_q;
  logic           done_q;

  logic [W-1:0]   load_san_c;
  logic [W-1:0]   count_dec_c;
  logic           count_is_one_c;
  logic           load_is_zero_c;

  // Clamp every preset nibble above 9 down to 9 so the count stays valid BCD.
  always_comb begin
    load_san_c = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (i_load_val[4*k +: 4] > 4'd9) begin
        load_san_c[4*k +: 4] = 4'd9;
      end else begin
        load_san_c[4*k +: 4] = i_load_val[4*k +: 4];
      end
    end
  end

  // BCD decrement by one: a digit at 0 wraps to 9 and borrows from the next digit up.
  always_comb begin
    logic borrow;
    count_dec_c = count_q;
    borrow      = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          count_dec_c[4*k +: 4] = 4'd9;
        end else begin
          count_dec_c[4*k +: 4] = 4'(count_q[4*k +: 4] - 4'd1);
          borrow                = 1'b0;
        end
      end
    end
  end

  // Terminal-count and zero-preset detection.
  always_comb begin
    count_is_one_c = (count_q == W'(1));
    load_is_zero_c = (load_san_c == '0);
  end

  // Control FSM and count register; input priority is stop > start > resume > en.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      preset_q <= '0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (i_stop) begin
        // Pause only takes effect from RUN; the same edge's tick is dropped.
        if (state_q == ST_RUN) begin
          state_q <= ST_PAUSED;
          busy_q  <= 1'b0;
        end
      end else if (i_start) begin
        // Load (or restart) from any state; an all-zero preset finishes immediately.
        preset_q <= load_san_c;
        if (load_is_zero_c) begin
          state_q <= ST_IDLE;
          count_q <= '0;
          busy_q  <= 1'b0;
          zero_q  <= 1'b1;
          done_q  <= 1'b1;
        end else begin
          state_q <= ST_RUN;
          count_q <= load_san_c;
          busy_q  <= 1'b1;
          zero_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          ST_RUN: begin
            if (i_en) begin
              if (count_is_one_c) begin
`ifdef AUTO_RELOAD_EN
                if (preset_q != '0) begin
                  count_q <= preset_q;
                  zero_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_IDLE;
                  count_q <= '0;
                  busy_q  <= 1'b0;
                  zero_q  <= 1'b1;
                  done_q  <= 1'b1;
                end
`else
                state_q <= ST_IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
                zero_q  <= 1'b1;
                done_q  <= 1'b1;
`endif
              end else if (count_q != '0) begin
                count_q <= count_dec_c;
              end
            end
          end
          ST_PAUSED: begin
            if (i_resume) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_count = count_q;
  assign o_busy  = busy_q;
  assign o_zero  = zero_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_bcd_downcounter.sv
// Directed bench for bcd_downcounter (DIGITS=2); AUTO_RELOAD_EN selects the reload scenario.
module tb_bcd_downcounter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       start;
  logic       stop;
  logic       resume;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy;
  logic       zero;
  logic       done;

  int checks;
  int errors;

  bcd_downcounter #(.DIGITS(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_start    (start),
    .i_stop     (stop),
    .i_resume   (resume),
    .i_load_val (load_val),
    .o_count    (count),
    .o_busy     (busy),
    .o_zero     (zero),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal 0..99 to two-digit BCD.
  function automatic logic [7:0] to_bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c, input logic b,
                         input logic z, input logic d);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".zero"},  32'(zero),  32'(z));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    resume   = 1'b0;
    load_val = 8'h00;
    step();
    step();
    chk_all("reset", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step();
    chk_all("post_reset", 8'h00, 1'b0, 1'b1, 1'b0);

`ifndef AUTO_RELOAD_EN
    // Test 1: preset 12, tick every other cycle.
    load_val = 8'h12;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk_all("t1_load", 8'h12, 1'b1, 1'b0, 1'b0);
    for (int v = 11; v >= 0; v--) begin
      en = 1'b1;
      step();
      chk_all("t1_tick", to_bcd(v), (v != 0), (v == 0), (v == 0));
      en = 1'b0;
      step();
      chk_all("t1_gap", to_bcd(v), (v != 0), (v == 0), 1'b0);
    end

    // Test 2: preset 30, en held high, borrows and saturation at 00.
    load_val = 8'h30;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk_all("t2_load", 8'h30, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    for (int v = 29; v >= 0; v--) begin
      step();
      chk_all("t2_tick", to_bcd(v), (v != 0), (v == 0), (v == 0));
    end
    for (int i = 0; i < 4; i++) begin
      step();
      chk_all("t2_hold0", 8'h00, 1'b0, 1'b1, 1'b0);
    end
    en = 1'b0;
`endif

    // Test 3: stop with simultaneous tick, ticks ignored while paused, resume.
    load_val = 8'h25;
    start    = 1'b1;
    step();
    start = 1'b0;
    en    = 1'b1;
    step();
    step();
    step();
    chk_all("t3_run", 8'h22, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_all("t3_stop", 8'h22, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk_all("t3_paused", 8'h22, 1'b0, 1'b0, 1'b0);
    en     = 1'b0;
    resume = 1'b1;
    step();
    resume = 1'b0;
    chk_all("t3_resume", 8'h22, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    step();
    step();
    en = 1'b0;
    chk_all("t3_after", 8'h20, 1'b1, 1'b0, 1'b0);

    // Test 4: sanitised preset, then zero preset from IDLE.
    load_val = 8'hAF;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk_all("t4_clamp", 8'h99, 1'b1, 1'b0, 1'b0);
    load_val = 8'hA7;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk_all("t4_restart", 8'h97, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n    = 1'b1;
    load_val = 8'h00;
    start    = 1'b1;
    step();
    start = 1'b0;
    chk_all("t4_zero_load", 8'h00, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("t4_zero_after", 8'h00, 1'b0, 1'b1, 1'b0);

    // Test 5: reset mid-count at 07 aborts with no done, ticks then ignored.
    load_val = 8'h09;
    start    = 1'b1;
    step();
    start = 1'b0;
    en    = 1'b1;
    step();
    step();
    chk_all("t5_run", 8'h07, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    chk_all("t5_reset", 8'h00, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("t5_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    end
    en = 1'b0;

`ifdef AUTO_RELOAD_EN
    // Test 6: auto-reload with preset 03, 9 ticks.
    load_val = 8'h03;
    start    = 1'b1;
    step();
    start    = 1'b0;
    load_val = 8'h55;
    chk_all("t6_load", 8'h03, 1'b1, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      case (i % 3)
        0:       chk_all("t6_tick", 8'h02, 1'b1, 1'b0, 1'b0);
        1:       chk_all("t6_tick", 8'h01, 1'b1, 1'b0, 1'b0);
        default: chk_all("t6_tick", 8'h03, 1'b1, 1'b0, 1'b1);
      endcase
    end
    en = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
